// File: rtl/regfile_2r1w.sv
// Parametrised DEPTH x WIDTH register file: one byte-enabled write port, two
// registered read ports with write-to-read bypass, synchronous clear, address-error pulse.
module regfile_2r1w #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [WIDTH/8-1:0] wr_be,
    input  logic               rd_en_a,
    input  logic [AW-1:0]      rd_addr_a,
    input  logic               rd_en_b,
    input  logic [AW-1:0]      rd_addr_b,
    output logic [WIDTH-1:0]   rd_data_a,
    output logic [WIDTH-1:0]   rd_data_b,
    output logic               rd_valid_a,
    output logic               rd_valid_b,
    input  logic               clr,
    output logic               addr_err
);

    localparam int            NB      = WIDTH / 8;
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_rd_en   [2];
    logic [AW-1:0]    w_rd_addr [2];
    logic [WIDTH-1:0] w_rd_next [2];
    logic [WIDTH-1:0] r_rd_data [2];
    logic             r_rd_valid[2];

    logic             w_wr_hit;
    logic [WIDTH-1:0] w_wr_old;
    logic [WIDTH-1:0] w_wr_merged;
    logic             w_err;
    logic             r_addr_err;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    assign w_rd_en[0]   = rd_en_a;
    assign w_rd_en[1]   = rd_en_b;
    assign w_rd_addr[0] = rd_addr_a;
    assign w_rd_addr[1] = rd_addr_b;

    // A write commits only when in range and not overridden by a clear.
    assign w_wr_hit = wr_en && !clr && in_range(wr_addr);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_wr_old = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_addr == AW'(i)) w_wr_old = r_mem[i];
        end
    end

    always_comb begin
        w_wr_merged = w_wr_old;
        for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) w_wr_merged[8*b +: 8] = wr_data[8*b +: 8];
        end
    end

    // Next read value equals what the addressed entry holds after this edge.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd_next[p] = '0;
            if (!clr && in_range(w_rd_addr[p])) begin
                if (w_wr_hit && (wr_addr == w_rd_addr[p])) begin
                    w_rd_next[p] = w_wr_merged;
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (w_rd_addr[p] == AW'(i)) w_rd_next[p] = r_mem[i];
                    end
                end
            end
        end
    end

    assign w_err = (wr_en   && (|wr_be) && !in_range(wr_addr))
                || (rd_en_a && !in_range(rd_addr_a))
                || (rd_en_b && !in_range(rd_addr_b));

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: storage is a flop array, so it is reset explicitly; all state uses non-blocking assignments.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_wr_hit) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_addr == AW'(i)) r_mem[i] <= w_wr_merged;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                r_rd_data[p]  <= '0;
                r_rd_valid[p] <= 1'b0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                r_rd_valid[p] <= w_rd_en[p];
                if (w_rd_en[p]) r_rd_data[p] <= w_rd_next[p];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_addr_err <= 1'b0;
        else     r_addr_err <= w_err;
    end

    assign rd_data_a  = r_rd_data[0];
    assign rd_data_b  = r_rd_data[1];
    assign rd_valid_a = r_rd_valid[0];
    assign rd_valid_b = r_rd_valid[1];
    assign addr_err   = r_addr_err;

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised register file that replaces single fixed-width registers wherever a small bank of addressable state is needed. It has one write port with byte enables, two independent registered read ports with write-to-read bypass, a synchronous bulk clear, and an out-of-range address flag. It sits between datapath stages as the general-purpose storage element, sharing one clock and one reset with the surrounding logic.

## Interface
- WIDTH, 64, entry width in bits; must be a multiple of 8
- DEPTH, 8, number of entries; 2 or more, need not be a power of two
- AW, $clog2(DEPTH), address width; derived, not overridden
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous and active-high: clears all entries and outputs immediately, independent of clk
- wr_en  input  1  write request this cycle
- wr_addr  input  AW  write address
- wr_data  input  WIDTH  write data
- wr_be  input  WIDTH/8  byte enables; bit i selects wr_data[8i+7:8i]
- rd_en_a / rd_en_b  input  1  read request, port A / B
- rd_addr_a / rd_addr_b  input  AW  read address, port A / B
- rd_data_a / rd_data_b  output  WIDTH  registered read data, port A / B
- rd_valid_a / rd_valid_b  output  1  rd_data updated this cycle, port A / B
- clr  input  1  synchronous clear of all entries
- addr_err  output  1  one-cycle pulse when any enabled access uses an address >= DEPTH

## Operation
- Storage: DEPTH x WIDTH flops. Reset value of every entry is 0.
- Write: when wr_en=1, clr=0, and wr_addr<DEPTH, each byte i with wr_be[i]=1 takes the new wr_data byte at the clock edge. Bytes with wr_be[i]=0 keep their old value. If wr_be is all zero, nothing changes and no error is raised.
- Read (each port independent): when rd_en=1, rd_data takes entry[rd_addr] at the edge and rd_valid=1 for the next cycle. When rd_en=0, rd_data holds its last value and rd_valid=0.
- Bypass: if a read and a write target the same in-range address in the same cycle, rd_data returns the merged result. That is, the new bytes where wr_be=1 and the old bytes elsewhere, which matches what the entry holds after the edge. Both ports bypass independently, including when both read the written address.
- Out of range (address >= DEPTH, possible only when DEPTH is not a power of two):
  - write: ignored
  - read: rd_data=0, rd_valid=1
  - either case: addr_err=1 in the following cycle
  - addr_err is a pulse, not sticky.
- Clear: when clr=1, all entries are 0 after the edge.
  - clr takes priority over a write in the same cycle; the write is discarded.
  - A read in the clr cycle returns 0 with rd_valid=1, consistent with the bypass rule.
  - addr_err still reports an out-of-range address in the clr cycle.

## Timing
- Write-to-storage latency: 1 edge. Read latency: 1 cycle, so an address presented in cycle n gives rd_data and rd_valid in cycle n+1.
- Back-to-back reads and writes are allowed every cycle, with no stalls and no handshake back-pressure.
- A read of an address written in cycle n-1 returns the new data, because storage is already updated.
- Reset asserted mid-operation: all entries, rd_data_a/b, rd_valid_a/b and addr_err go to 0 asynchronously.
  - Accesses in the reset-release cycle are honoured from the first rising edge after rst deasserts.
  - Accesses sampled while rst=1 are lost.
- Outputs are driven only from flops; there is no combinational path from inputs to outputs.

## Test plan
- Reset and basic read/write:
  - pulse rst, read all addresses on both ports -> every rd_data=0, rd_valid=1, addr_err=0
  - write 0x0123456789ABCDEF to addr 3 with wr_be=0xFF, read addr 3 on port A next cycle -> rd_data_a=0x0123456789ABCDEF
- Byte enables: entry 5 = 0x1111111111111111, write 0xFFFFFFFFFFFFFFFF with wr_be=0x0F -> read gives 0x11111111FFFFFFFF.
- Bypass: entry 2 = 0xAAAA_AAAA_AAAA_AAAA. In the same cycle, write 0x5555_5555_5555_5555 with wr_be=0xF0 to addr 2 and read addr 2 on both ports -> both rd_data=0x5555_5555_AAAA_AAAA.
- Clear priority: in the same cycle, clr=1, a write of 0xDEAD to addr 1, and a port B read of addr 1 -> rd_data_b=0. A later read of addr 1 also returns 0, and every other entry reads 0.
- Out of range (DEPTH=6):
  - write to addr 7 -> addr_err=1 for one cycle, no entry changes
  - read addr 6 on port A -> rd_data_a=0, rd_valid_a=1, addr_err pulses
- Async reset mid-stream: during continuous random traffic, raise rst between edges -> all outputs are 0 before the next edge. After release, the first write and read behave as in the basic read/write case.
